// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone widths and arbiter state encoding
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN0,
    ARB_OWN1
  } arb_state_t;

  // Ownership state for a given controller port index.
  function automatic arb_state_t own_state(input logic port);
    return port ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// rtl/wb_arbiter2_if.sv - B4 pipelined Wishbone bundle with controller/peripheral views
interface wb_arbiter2_if;
  import wb_pkg::*;

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [WB_SEL_W-1:0]  sel;
  logic [WB_ADDR_W-1:0] addr;
  logic [WB_DATA_W-1:0] wdata;
  logic [WB_DATA_W-1:0] rdata;
  logic                 ack;
  logic                 stall;

  // Side that issues requests.
  modport controller (
    output cyc, stb, we, sel, addr, wdata,
    input  rdata, ack, stall
  );

  // Side that services requests.
  modport peripheral (
    input  cyc, stb, we, sel, addr, wdata,
    output rdata, ack, stall
  );

endinterface

// File: rtl/wb_outstanding_ctr.sv
// rtl/wb_outstanding_ctr.sv - accepted-but-unacked request counter with cap flag
module wb_outstanding_ctr #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clr,
  output logic o_full
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          inc_eff;
  logic          dec_eff;

  // Cap is judged on the registered count; an ack in the same cycle only
  // takes effect on the following cycle.
  assign o_full = (count_q == CW'(MAX_OUTSTANDING));

  // An ack with nothing outstanding (e.g. a stray after abort) is ignored.
  assign dec_eff = i_dec && (count_q != '0);
  assign inc_eff = i_inc && !o_full;

  // Next count: clear wins, simultaneous accept and ack cancel out.
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (inc_eff && !dec_eff) begin
      count_d = count_q + CW'(1);
    end else if (!inc_eff && dec_eff) begin
      count_d = count_q - CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-to-one pipelined Wishbone arbiter, round-robin per bus cycle
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ROUND_ROBIN     = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  wb_arbiter2_if.peripheral  c0,
  wb_arbiter2_if.peripheral  c1,
  wb_arbiter2_if.controller  p
);

  arb_state_t grant_q;
  arb_state_t grant_d;
  logic       last_q;
  logic       last_d;
  logic       release_w;
  logic       ctr_full;
  logic       ctr_clr;
  logic       ctr_dec;
  logic       stb_fwd;

  // Owner dropping cyc ends its ownership in that same cycle.
  assign release_w = ((grant_q == ARB_OWN0) && !c0.cyc) ||
                     ((grant_q == ARB_OWN1) && !c1.cyc);

  // Counter is held at zero whenever nobody owns the bus, so a stray ack
  // after release can never leak into the next owner's accounting.
  assign ctr_clr = (grant_q == ARB_IDLE) || release_w;
  assign ctr_dec = p.ack && (grant_q != ARB_IDLE);

  wb_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_ctr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (stb_fwd && !p.stall),
    .i_dec   (ctr_dec),
    .i_clr   (ctr_clr),
    .o_full  (ctr_full)
  );

  // Next ownership: grant from IDLE only, hold while the owner keeps cyc.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    case (grant_q)
      ARB_IDLE: begin
        if (c0.cyc && c1.cyc) begin
          grant_d = (ROUND_ROBIN != 0) ? own_state(!last_q) : ARB_OWN0;
        end else if (c0.cyc) begin
          grant_d = ARB_OWN0;
        end else if (c1.cyc) begin
          grant_d = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        if (!c0.cyc) begin
          grant_d = ARB_IDLE;
          last_d  = 1'b0;
        end
      end
      ARB_OWN1: begin
        if (!c1.cyc) begin
          grant_d = ARB_IDLE;
          last_d  = 1'b1;
        end
      end
      default: begin
        grant_d = ARB_IDLE;
      end
    endcase
  end

  // Ownership and last-served registers; port 0 wins the first contention.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign p.stb = stb_fwd;

  // Request mux to the peripheral and response demux back to the owner.
  always_comb begin
    stb_fwd  = 1'b0;
    p.cyc    = 1'b0;
    p.we     = 1'b0;
    p.sel    = '0;
    p.addr   = '0;
    p.wdata  = '0;
    c0.stall = 1'b1;
    c0.ack   = 1'b0;
    c0.rdata = '0;
    c1.stall = 1'b1;
    c1.ack   = 1'b0;
    c1.rdata = '0;
    case (grant_q)
      ARB_OWN0: begin
        p.cyc    = c0.cyc;
        stb_fwd  = c0.stb && !ctr_full;
        p.we     = c0.we;
        p.sel    = c0.sel;
        p.addr   = c0.addr;
        p.wdata  = c0.wdata;
        c0.stall = p.stall || ctr_full;
        c0.ack   = p.ack;
        c0.rdata = p.rdata;
      end
      ARB_OWN1: begin
        p.cyc    = c1.cyc;
        stb_fwd  = c1.stb && !ctr_full;
        p.we     = c1.we;
        p.sel    = c1.sel;
        p.addr   = c1.addr;
        p.wdata  = c1.wdata;
        c1.stall = p.stall || ctr_full;
        c1.ack   = p.ack;
        c1.rdata = p.rdata;
      end
      default: begin
      end
    endcase
  end

endmodule
